// File: rtl/lsq_mem_ctrl.sv
// LSQ head to data-memory sequencer: store retirement, load issue, CDB write-back.
// Optional watchdog enabled with `define LSQ_CTRL_WDOG_EN.
package lsq_pkg;
  typedef struct packed {
    logic [31:0] address;
    logic [31:0] result;
    logic [3:0]  ROB_entry;
  } lsq_packet_t;

  typedef struct packed {
    logic [3:0]  dest_ROB_entry;
    logic [31:0] result;
  } CDB_packet_t;
endpackage

module lsq_mem_ctrl
  import lsq_pkg::*;
#(
  parameter int TIMEOUT = 64
) (
  input  logic        clk,
  input  logic        reset,
  input  logic        lsq_empty,
  input  logic        lsq_head_ready,
  input  logic        lsq_head_load,
  input  lsq_packet_t lsq_head,
  output logic        lsq_rd_en,
  input  logic [3:0]  rob_head_entry,
  input  logic        rob_head_store,
  output logic        store_commit,
  output logic        dmem_req,
  output logic        dmem_we,
  output logic [31:0] dmem_addr,
  output logic [31:0] dmem_wdata,
  input  logic        dmem_ack,
  input  logic        dmem_rvalid,
  input  logic [31:0] dmem_rdata,
  output logic        cdb_req,
  input  logic        cdb_grant,
  output CDB_packet_t cdb_out,
  output logic        err
);

  localparam logic [2:0] S_IDLE    = 3'd0;
  localparam logic [2:0] S_LD_REQ  = 3'd1;
  localparam logic [2:0] S_LD_WAIT = 3'd2;
  localparam logic [2:0] S_CDB_REQ = 3'd3;
  localparam logic [2:0] S_ST_REQ  = 3'd4;

  logic [2:0]  state_q, state_d;
  logic [3:0]  tag_q, tag_d;
  logic [31:0] addr_q, addr_d;
  logic [31:0] wdata_q, wdata_d;
  logic        req_q, req_d;
  logic        we_q, we_d;
  logic        cdbreq_q, cdbreq_d;
  CDB_packet_t cdb_q, cdb_d;
  logic        ld_go, st_go;

  assign ld_go = !lsq_empty && lsq_head_ready && lsq_head_load;
  assign st_go = !lsq_empty && lsq_head_ready && !lsq_head_load
              && rob_head_store
              && (rob_head_entry == lsq_head.ROB_entry);

`ifdef LSQ_CTRL_WDOG_EN
  localparam logic [7:0] TO_LAST = 8'(TIMEOUT - 1);
  logic [7:0] cnt_q, cnt_d;
  logic       err_q, err_d;
`endif

  always_comb begin
    state_d      = state_q;
    tag_d        = tag_q;
    addr_d       = addr_q;
    wdata_d      = wdata_q;
    cdb_d        = cdb_q;
    lsq_rd_en    = 1'b0;
    store_commit = 1'b0;
    case (state_q)
      S_IDLE: begin
        if (ld_go) begin
          addr_d  = lsq_head.address;
          tag_d   = lsq_head.ROB_entry;
          state_d = S_LD_REQ;
        end else if (st_go) begin
          addr_d  = lsq_head.address;
          wdata_d = lsq_head.result;
          state_d = S_ST_REQ;
        end
      end
      S_LD_REQ: begin
        if (dmem_ack) state_d = S_LD_WAIT;
      end
      S_LD_WAIT: begin
        if (dmem_rvalid) begin
          cdb_d   = '{dest_ROB_entry: tag_q, result: dmem_rdata};
          state_d = S_CDB_REQ;
        end
      end
      S_CDB_REQ: begin
        if (cdb_grant) begin
          lsq_rd_en = 1'b1;
          state_d   = S_IDLE;
        end
      end
      S_ST_REQ: begin
        if (dmem_ack) begin
          lsq_rd_en    = 1'b1;
          store_commit = 1'b1;
          state_d      = S_IDLE;
        end
      end
      default: state_d = S_IDLE;
    endcase

`ifdef LSQ_CTRL_WDOG_EN
    // A stuck wait state abandons the entry; it stays at the head and is retried.
    err_d = err_q;
    if (state_q != S_IDLE && state_d == state_q && cnt_q == TO_LAST) begin
      state_d = S_IDLE;
      err_d   = 1'b1;
    end
    if (state_d != state_q || state_q == S_IDLE) cnt_d = '0;
    else                                         cnt_d = cnt_q + 8'd1;
`endif

    req_d    = (state_d == S_LD_REQ) || (state_d == S_ST_REQ);
    we_d     = (state_d == S_ST_REQ);
    cdbreq_d = (state_d == S_CDB_REQ);
    if (state_d != S_CDB_REQ) cdb_d = '0;
  end

  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      state_q  <= S_IDLE;
      tag_q    <= '0;
      addr_q   <= '0;
      wdata_q  <= '0;
      req_q    <= 1'b0;
      we_q     <= 1'b0;
      cdbreq_q <= 1'b0;
      cdb_q    <= '0;
    end else begin
      state_q  <= state_d;
      tag_q    <= tag_d;
      addr_q   <= addr_d;
      wdata_q  <= wdata_d;
      req_q    <= req_d;
      we_q     <= we_d;
      cdbreq_q <= cdbreq_d;
      cdb_q    <= cdb_d;
    end
  end

`ifdef LSQ_CTRL_WDOG_EN
  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      cnt_q <= '0;
      err_q <= 1'b0;
    end else begin
      cnt_q <= cnt_d;
      err_q <= err_d;
    end
  end

  assign err = err_q;
`else
  assign err = 1'b0;
`endif

  assign dmem_req   = req_q;
  assign dmem_we    = we_q;
  assign dmem_addr  = addr_q;
  assign dmem_wdata = wdata_q;
  assign cdb_req    = cdbreq_q;
  assign cdb_out    = cdb_q;

endmodule
